// File: rtl/cpu_multicycle_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/execute over a shared ALU and
// unified memory port, with memory-ready stalls, a retire pulse and a sticky trap.
module cpu_multicycle_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_ctrl,
  output logic       imm_unsigned,
  output logic [1:0] pc_src,
  output logic       instr_done,
  output logic       trap,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_RD = 4'd3,
    S_MEM_WB = 4'd4, S_MEM_WR = 4'd5, S_R_EXEC = 4'd6, S_R_WB = 4'd7,
    S_BRANCH = 4'd8, S_JUMP = 4'd9, S_I_EXEC = 4'd10, S_I_WB = 4'd11,
    S_TRAP = 4'd12
  } state_e;

  localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR  = 4'b0001, ALU_ADD = 4'b0010,
                         ALU_SUB = 4'b0110, ALU_SLT = 4'b0111, ALU_NOR = 4'b1100;

  state_e     r_state, w_next, w_st;
  logic       w_r_legal;
  logic [3:0] w_r_alu, w_i_alu;
  logic       w_i_uns;

  always_comb begin
    w_r_legal = 1'b1;
    w_r_alu   = ALU_ADD;
    case (funct)
      6'h20: w_r_alu = ALU_ADD;
      6'h22: w_r_alu = ALU_SUB;
      6'h24: w_r_alu = ALU_AND;
      6'h25: w_r_alu = ALU_OR;
      6'h27: w_r_alu = ALU_NOR;
      6'h2A: w_r_alu = ALU_SLT;
      default: w_r_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_i_alu = ALU_ADD;
    w_i_uns = 1'b0;
    case (opcode)
      6'h0A: w_i_alu = ALU_SLT;
      6'h0C: begin w_i_alu = ALU_AND; w_i_uns = 1'b1; end
      6'h0D: begin w_i_alu = ALU_OR;  w_i_uns = 1'b1; end
      default: w_i_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    w_next = S_TRAP;
    case (r_state)
      S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:
        case (opcode)
          6'h00:                      w_next = w_r_legal ? S_R_EXEC : S_TRAP;
          6'h23, 6'h2B:               w_next = S_MEM_ADDR;
          6'h04, 6'h05:               w_next = S_BRANCH;
          6'h02:                      w_next = S_JUMP;
          6'h08, 6'h0A, 6'h0C, 6'h0D: w_next = S_I_EXEC;
          default:                    w_next = S_TRAP;
        endcase
      S_MEM_ADDR: w_next = (opcode == 6'h23) ? S_MEM_RD :
                           (opcode == 6'h2B) ? S_MEM_WR : S_TRAP;
      S_MEM_RD:   w_next = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   w_next = S_FETCH;
      S_MEM_WR:   w_next = mem_ready ? S_FETCH : S_MEM_WR;
      S_R_EXEC:   w_next = S_R_WB;
      S_R_WB:     w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_JUMP:     w_next = S_FETCH;
      S_I_EXEC:   w_next = S_I_WB;
      S_I_WB:     w_next = S_FETCH;
      default:    w_next = S_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= state_e'(RESET_STATE);
    else       r_state <= w_next;
  end

  // While reset is high the strobes look like FETCH, but nothing is written.
  assign w_st = reset ? S_FETCH : r_state;

  always_comb begin
    pc_write = 1'b0; ir_write = 1'b0; iord = 1'b0; mem_read = 1'b0;
    mem_write = 1'b0; reg_write = 1'b0; reg_dst = 1'b0; mem_to_reg = 1'b0;
    alu_src_a = 1'b0; alu_src_b = 2'b00; alu_ctrl = ALU_AND;
    imm_unsigned = 1'b0; pc_src = 2'b00; instr_done = 1'b0; trap = 1'b0;
    case (w_st)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_ctrl  = ALU_ADD;
        pc_write  = mem_ready & ~reset;
        ir_write  = mem_ready & ~reset;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_ctrl  = ALU_ADD;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = ALU_ADD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_ctrl  = w_r_alu;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        alu_ctrl   = w_r_alu;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_ctrl   = ALU_SUB;
        pc_src     = 2'b01;
        pc_write   = ((opcode == 6'h04) & alu_zero) | ((opcode == 6'h05) & ~alu_zero);
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        alu_ctrl     = w_i_alu;
        imm_unsigned = w_i_uns;
      end
      S_I_WB: begin
        reg_write    = 1'b1;
        alu_ctrl     = w_i_alu;
        imm_unsigned = w_i_uns;
        instr_done   = 1'b1;
      end
      S_TRAP:  trap = 1'b1;
      default: trap = 1'b0;
    endcase
  end

  assign state = r_state;

endmodule

// File: doc/cpu_multicycle_ctrl.md
Name: cpu_multicycle_ctrl

Overview:
- Moore/Mealy control FSM that sequences a shared-resource multi-cycle datapath: one ALU, one unified instruction/data memory port, IR, MDR, A/B and ALUOut registers.
- Executes the same instruction subset as the single-cycle core over 3–5 states per instruction.
- Adds a memory-ready handshake, a retire pulse and a sticky trap state for illegal encodings. These feed the team's fault-monitoring logic.

Parameters:
- RESET_STATE, 4'd0: state entered on reset (FETCH); only FETCH is supported.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high; clock clk
- opcode  input  6  IR[31:26], valid from DECODE onward
- funct  input  6  IR[5:0]
- alu_zero  input  1  ALU zero flag, combinational from datapath
- mem_ready  input  1  memory access completes this cycle
- pc_write  output  1  load PC this cycle
- ir_write  output  1  load IR from memory read data
- iord  output  1  memory address: 0=PC, 1=ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request (data=B)
- reg_write  output  1  register-file write
- reg_dst  output  1  write address: 1=rd, 0=rt
- mem_to_reg  output  1  write data: 1=MDR, 0=ALUOut
- alu_src_a  output  1  0=PC, 1=A
- alu_src_b  output  2  00=B, 01=const 4, 10=imm_ext, 11=imm_ext<<2
- alu_ctrl  output  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
- imm_unsigned  output  1  zero-extend immediate (andi/ori)
- pc_src  output  2  00=ALU result, 01=ALUOut, 10=jump target
- instr_done  output  1  one-cycle pulse when an instruction retires
- trap  output  1  sticky illegal-instruction flag
- state  output  4  current state, for debug

Behaviour:
- Reset:
  - state=FETCH. All outputs are registered-state-decoded; during the reset cycle and the first FETCH cycle, all strobes are 0 except those FETCH defines.
  - trap=0 and instr_done=0 after reset.
  - Reset mid-instruction abandons the instruction with no write.
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11, TRAP=12.
  - Codes 13–15 go to TRAP on the next edge.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=ADD, pc_src=00. While mem_ready=0, hold the state with ir_write=pc_write=0. When mem_ready=1: ir_write=pc_write=1 and go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, ADD (branch target into ALUOut). Dispatch on opcode:
  - 0x00: R_EXEC if funct ∈ {0x20,0x22,0x24,0x25,0x27,0x2A}, else TRAP.
  - 0x23, 0x2B: MEM_ADDR.
  - 0x04, 0x05: BRANCH.
  - 0x02: JUMP.
  - 0x08, 0x0A, 0x0C, 0x0D: I_EXEC.
  - Anything else: TRAP.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD, imm_unsigned=0. lw → MEM_RD; sw → MEM_WR.
- MEM_RD: mem_read=1, iord=1; hold until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1 → FETCH.
- MEM_WR: mem_write=1, iord=1; hold until mem_ready. On ready: instr_done=1 → FETCH. mem_write stays asserted throughout the hold.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_ctrl from funct (0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x2A SLT) → R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, alu_ctrl held, instr_done=1 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_src=01, pc_write = (opcode==0x04 & alu_zero) | (opcode==0x05 & ~alu_zero), instr_done=1 → FETCH.
- JUMP: pc_src=10, pc_write=1, instr_done=1 → FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10.
  - 0x08 ADD; 0x0A SLT; 0x0C AND with imm_unsigned=1; 0x0D OR with imm_unsigned=1.
  - → I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, same alu_ctrl/imm_unsigned, instr_done=1 → FETCH.
- TRAP: all strobes 0, trap=1. Stays in TRAP until reset.
- No memory request is ever issued while mem_ready is unknown. mem_ready outside the memory states is ignored.
- CPI: R/I-type 4, lw 5, sw 4, branch/jump 3, each plus memory wait cycles.

Test Plan:
- Reset held 2 cycles, mem_ready=1, IR=add (0x00, funct 0x20) → state 0→1→6→7→0; pc_write and ir_write in cycle 1; reg_write=1, reg_dst=1 in cycle 4; instr_done single pulse.
- lw (0x23) with mem_ready low for 3 cycles in MEM_RD → state holds at 3 with mem_read=1, iord=1; MEM_WB reg_write=1, mem_to_reg=1; total 8 cycles.
- beq (0x04) with alu_zero=1, then bne (0x05) with alu_zero=1 → pc_write=1, pc_src=01 for beq; pc_write=0 for bne; 3 cycles each.
- ori (0x0D) → I_EXEC/I_WB with alu_ctrl=0001, imm_unsigned=1, reg_dst=0. slti (0x0A) → alu_ctrl=0111, imm_unsigned=0.
- Opcode 0x3F, then R-type funct 0x00 → TRAP entered from DECODE; trap=1; all strobes 0 for 20 cycles. Reset returns to FETCH with trap=0.
- Reset asserted in MEM_WR with mem_ready=0 → next state FETCH, mem_write=0 immediately after the reset edge, no instr_done.
